// File: rtl/adder_issue_queue_if.sv
// Bundle of the producer-side handshake, the adder-side issue port and the
// queue's status outputs. The queue connects through the slave modport; the
// driving environment (producer + adder) connects through the master modport.
//
// Handshake: the producer holds s_in1/s_in2 stable with s_valid high until a
// rising edge where s_ready is also high; that edge transfers one pair.
// s_ready never depends on s_valid. m_ivalid is a one-cycle issue pulse with
// m_in1/m_in2 valid in the same cycle; the adder has no ready on this side.
interface adder_issue_queue_if #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [DWIDTH-1:0] s_in1;
    logic [DWIDTH-1:0] s_in2;
    logic              s_valid;
    logic              s_ready;

    logic [DWIDTH-1:0] m_in1;
    logic [DWIDTH-1:0] m_in2;
    logic              m_ivalid;
    logic              adder_busy;
    logic              adder_ovalid;

    logic [LW-1:0]     level;
    logic              idle;
    logic              err;
    logic [1:0]        dbg_state;

    modport master (
        output s_in1, s_in2, s_valid, adder_busy, adder_ovalid,
        input  s_ready, m_in1, m_in2, m_ivalid, level, idle, err, dbg_state
    );

    modport slave (
        input  s_in1, s_in2, s_valid, adder_busy, adder_ovalid,
        output s_ready, m_in1, m_in2, m_ivalid, level, idle, err, dbg_state
    );
endinterface

// File: rtl/adder_issue_queue.sv
// adder_issue_queue: operand FIFO in front of the adder wrapper. Pairs are
// issued one at a time as a registered ivalid pulse, throttled by the adder's
// busy plus a settle cycle, or back-to-back when PIPELINED. Outstanding
// operations are counted against ovalid to derive idle and a sticky err.
module adder_issue_queue #(
    parameter int DWIDTH    = 8,
    parameter int DEPTH     = 4,
    parameter bit PIPELINED = 1'b0
) (
    input logic                clk,
    input logic                rst,
    adder_issue_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int OW = AW + 4;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [OW-1:0] OUT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t            state_q;
    logic [DWIDTH-1:0] mem1_q [DEPTH];
    logic [DWIDTH-1:0] mem2_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic              err_q, err_d;
    logic [DWIDTH-1:0] m_in1_q, m_in2_q;
    logic              m_ivalid_q;
    logic              push;
    logic              pop;

    // Accept only on the registered count; a same-cycle pop is not looked at.
    assign push = bus.s_valid && (level_q != FULL_LEVEL);

    // Decide whether the head is issued at the coming edge.
    always_comb begin
        pop = 1'b0;
        unique case (state_q)
            ST_IDLE:   pop = (level_q != '0) && (PIPELINED || !bus.adder_busy);
            ST_ISSUE:  pop = PIPELINED && (level_q != '0);
            ST_SETTLE: pop = 1'b0;
            default:   pop = 1'b0;
        endcase
    end

    // FIFO pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^n).
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Outstanding count: issue increments, completion decrements, saturating;
    // a completion with nothing outstanding latches err instead.
    always_comb begin
        outst_d = outst_q;
        err_d   = err_q;
        unique case ({m_ivalid_q, bus.adder_ovalid})
            2'b10: begin
                if (outst_q != OUT_MAX) outst_d = outst_q + OW'(1);
            end
            2'b01: begin
                if (outst_q == '0) err_d = 1'b1;
                else               outst_d = outst_q - OW'(1);
            end
            default: outst_d = outst_q;
        endcase
    end

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem1_q[wr_ptr_q] <= bus.s_in1;
            mem2_q[wr_ptr_q] <= bus.s_in2;
        end
    end

    // FIFO pointers, occupancy, outstanding counter and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            outst_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            outst_q  <= outst_d;
            err_q    <= err_d;
        end
    end

    // Issue FSM with registered operand and ivalid outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            m_in1_q    <= '0;
            m_in2_q    <= '0;
            m_ivalid_q <= 1'b0;
        end else begin
            m_ivalid_q <= pop;
            if (pop) begin
                m_in1_q <= mem1_q[rd_ptr_q];
                m_in2_q <= mem2_q[rd_ptr_q];
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (pop) state_q <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (PIPELINED) state_q <= pop ? ST_ISSUE : ST_IDLE;
                    else           state_q <= ST_SETTLE;
                end
                ST_SETTLE: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.s_ready   = (level_q != FULL_LEVEL);
    assign bus.m_in1     = m_in1_q;
    assign bus.m_in2     = m_in2_q;
    assign bus.m_ivalid  = m_ivalid_q;
    assign bus.level     = level_q;
    assign bus.idle      = (level_q == '0) && (outst_q == '0) && (state_q == ST_IDLE);
    assign bus.err       = err_q;
    assign bus.dbg_state = state_q;
endmodule
